// File: rtl/proc_drv_pkg.sv
// ---------------------------------------------------------------------------
// proc_drv_pkg
// Shared types for the processor driver:
//   op_e    - command opcodes (OP_RST, OP_LDA, OP_LDB, OP_EXEC)
//   cmd_t   - one command: {op, data, f, r, exp_a, exp_b}
//   state_e - driver FSM states
//   TIMER_W - width of the shared phase down-counter
//   button_of() - which button a given op presses
// ---------------------------------------------------------------------------
package proc_drv_pkg;

  typedef enum logic [1:0] {
    OP_RST  = 2'd0,
    OP_LDA  = 2'd1,
    OP_LDB  = 2'd2,
    OP_EXEC = 2'd3
  } op_e;

  typedef struct packed {
    op_e        op;
    logic [7:0] data;
    logic [2:0] f;
    logic [1:0] r;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    PRESS   = 3'd2,
    GAP     = 3'd3,
    SETTLE  = 3'd4,
    CAPTURE = 3'd5,
    FINISH  = 3'd6
  } state_e;

  // 5 bits covers phase lengths 1..32.
  localparam int TIMER_W = 5;

  // Active-high "pressed" mask, ordered {load_a, load_b, execute, reset}.
  function automatic logic [3:0] button_of(op_e op);
    logic [3:0] m;
    m = 4'b0000;
    case (op)
      OP_LDA:  m = 4'b1000;
      OP_LDB:  m = 4'b0100;
      OP_EXEC: m = 4'b0010;
      OP_RST:  m = 4'b0001;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/processor_driver_phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
// Loadable down-counter shared by every timed phase of the driver.
// A phase of N cycles is started by loading N-1; zero is high in the last
// cycle of the phase. The counter parks at zero when not loaded.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous, active-high
//   load     in  load load_val this cycle
//   load_val in  TIMER_W  value to load (phase length - 1)
//   zero     out count is zero
// ---------------------------------------------------------------------------
module phase_timer
  import proc_drv_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/processor_driver.sv
// ---------------------------------------------------------------------------
// processor_driver
// Command-driven initiator for the 8-bit logic processor. Each accepted
// command holds Din/F/R stable, then presses exactly one button with fixed
// setup / press / gap timing. EXEC additionally waits for the shift to
// settle and captures the processor's A/B registers.
//
// Optional build macro: PROC_DRV_CHECK_EN
//   defined   - captured {Aval,Bval} are compared with {exp_a,exp_b};
//               Mismatch pulses with Done, ErrCount counts (saturating).
//   undefined - no compare logic; Mismatch=0, ErrCount=8'h00.
//
// Ports:
//   Clk, Reset           clock, synchronous active-high reset
//   CmdValid/CmdReady    command handshake, Cmd = cmd_t payload
//   Din, F, R            processor data / function / routing switches
//   LoadA, LoadB         buttons, active-high
//   ExecuteBtn, ResetBtn buttons, active-low
//   Aval, Bval           processor registers A and B
//   ResA, ResB           A/B captured at the end of the last EXEC
//   Busy, Done           not idle / one-cycle completion pulse
//   Mismatch, ErrCount   result check outputs (macro only)
//   dbg_state            current FSM state
//
// Handshake: a command transfers on a rising Clk edge where both CmdValid
// and CmdReady are high. CmdReady is high only in IDLE and depends only on
// state, never on CmdValid. While busy, CmdValid is ignored: nothing is
// queued and the requester must hold its command until CmdReady returns.
// ---------------------------------------------------------------------------
module processor_driver
  import proc_drv_pkg::*;
#(
  parameter int SETUP_CYC  = 3,
  parameter int PRESS_CYC  = 4,
  parameter int GAP_CYC    = 4,
  parameter int SETTLE_CYC = 12
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       CmdValid,
  output logic       CmdReady,
  input  cmd_t       Cmd,
  output logic [7:0] Din,
  output logic [2:0] F,
  output logic [1:0] R,
  output logic       LoadA,
  output logic       LoadB,
  output logic       ExecuteBtn,
  output logic       ResetBtn,
  input  logic [7:0] Aval,
  input  logic [7:0] Bval,
  output logic [7:0] ResA,
  output logic [7:0] ResB,
  output logic       Busy,
  output logic       Done,
  output logic       Mismatch,
  output logic [7:0] ErrCount,
  output state_e     dbg_state
);

  // Phase lengths must be 1..32 so that N-1 fits the 5-bit counter.
  if (SETUP_CYC < 1 || PRESS_CYC < 1 || GAP_CYC < 1 || SETTLE_CYC < 1) begin : g_bad_zero
    $error("processor_driver: phase cycle parameters must be nonzero");
  end
  if (SETUP_CYC > 32 || PRESS_CYC > 32 || GAP_CYC > 32 || SETTLE_CYC > 32) begin : g_bad_big
    $error("processor_driver: phase cycle parameters must not exceed 32");
  end

  localparam logic [TIMER_W-1:0] SETUP_LD  = TIMER_W'(SETUP_CYC - 1);
  localparam logic [TIMER_W-1:0] PRESS_LD  = TIMER_W'(PRESS_CYC - 1);
  localparam logic [TIMER_W-1:0] GAP_LD    = TIMER_W'(GAP_CYC - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LD = TIMER_W'(SETTLE_CYC - 1);

  state_e             state, state_n;
  cmd_t               cmd_q;
  logic               accept;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_zero;
  logic [3:0]         pressed;

  phase_timer u_timer (
    .clk      (Clk),
    .reset    (Reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and timer loads. Each timed phase loads the timer for the
  // following phase in its last cycle, so phases run back to back.
  always_comb begin
    state_n  = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (CmdValid) begin
          accept   = 1'b1;
          state_n  = SETUP;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          state_n  = PRESS;
          tmr_load = 1'b1;
          tmr_val  = PRESS_LD;
        end
      end
      PRESS: begin
        if (tmr_zero) begin
          state_n  = GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      GAP: begin
        if (tmr_zero) begin
          if (cmd_q.op == OP_EXEC) begin
            state_n  = SETTLE;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LD;
          end else begin
            state_n = FINISH;
          end
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          state_n = CAPTURE;
        end
      end
      CAPTURE: state_n = FINISH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Command register and result capture
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cmd_q <= '0;
      ResA  <= '0;
      ResB  <= '0;
    end else begin
      if (accept) begin
        cmd_q <= Cmd;
      end
      if (state == CAPTURE) begin
        ResA <= Aval;
        ResB <= Bval;
      end
    end
  end

  // Switches follow the last accepted command and are never cleared by
  // completion; only Reset returns them to zero.
  assign Din = cmd_q.data;
  assign F   = cmd_q.f;
  assign R   = cmd_q.r;

  // Only one button can be active: the mask is one-hot per op and gated
  // by PRESS, so a reset into IDLE releases everything on the next cycle.
  assign pressed    = (state == PRESS) ? button_of(cmd_q.op) : 4'b0000;
  assign LoadA      = pressed[3];
  assign LoadB      = pressed[2];
  assign ExecuteBtn = ~pressed[1];
  assign ResetBtn   = ~pressed[0];

  assign CmdReady  = (state == IDLE);
  assign Busy      = (state != IDLE);
  assign Done      = (state == FINISH);
  assign dbg_state = state;

`ifdef PROC_DRV_CHECK_EN
  logic       mis_q;
  logic [7:0] err_q;
  logic       mis_now;

  assign mis_now = ({Aval, Bval} != {cmd_q.exp_a, cmd_q.exp_b});

  // The compare result is held from CAPTURE into FINISH so Mismatch lines
  // up with Done.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mis_q <= 1'b0;
      err_q <= '0;
    end else if (state == CAPTURE) begin
      mis_q <= mis_now;
      if (mis_now && err_q != 8'hFF) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

  assign Mismatch = (state == FINISH) && mis_q;
  assign ErrCount = err_q;
`else
  logic unused_exp;
  assign unused_exp = ^{cmd_q.exp_a, cmd_q.exp_b};
  assign Mismatch   = 1'b0;
  assign ErrCount   = 8'h00;
`endif

endmodule

// File: tb/tb_processor_driver.sv
// ---------------------------------------------------------------------------
// tb_processor_driver
// Bench for processor_driver with a small behavioural stand-in for the
// 8-bit logic processor (A/B registers, AND/OR/XOR/NAND, routing, delayed
// execute). Build with +define+PROC_DRV_CHECK_EN to exercise the checker.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_processor_driver;
  import proc_drv_pkg::*;

  // ---------------- clock / reset ----------------
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       CmdValid = 1'b0;
  cmd_t       Cmd = '0;
  logic       CmdReady;
  logic [7:0] Din;
  logic [2:0] F;
  logic [1:0] R;
  logic       LoadA, LoadB, ExecuteBtn, ResetBtn;
  logic [7:0] Aval, Bval, ResA, ResB, ErrCount;
  logic       Busy, Done, Mismatch;
  state_e     dbg_state;

  always #5 Clk = ~Clk;

  processor_driver dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .CmdValid   (CmdValid),
    .CmdReady   (CmdReady),
    .Cmd        (Cmd),
    .Din        (Din),
    .F          (F),
    .R          (R),
    .LoadA      (LoadA),
    .LoadB      (LoadB),
    .ExecuteBtn (ExecuteBtn),
    .ResetBtn   (ResetBtn),
    .Aval       (Aval),
    .Bval       (Bval),
    .ResA       (ResA),
    .ResB       (ResB),
    .Busy       (Busy),
    .Done       (Done),
    .Mismatch   (Mismatch),
    .ErrCount   (ErrCount),
    .dbg_state  (dbg_state)
  );

  // ---------------- processor stand-in ----------------
  logic [7:0] pa = 8'h00, pb = 8'h00;
  logic       exec_prev = 1'b1;
  int         exec_cnt = 0;
  logic [2:0] pf = 3'b000;
  logic [1:0] pr = 2'b00;

  function automatic logic [7:0] alu(logic [2:0] f, logic [7:0] a, logic [7:0] b);
    case (f)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  always @(posedge Clk) begin
    exec_prev <= ExecuteBtn;
    if (!ResetBtn) begin
      pa <= 8'h00;
      pb <= 8'h00;
    end else if (LoadA) begin
      pa <= Din;
    end else if (LoadB) begin
      pb <= Din;
    end
    if (exec_prev && !ExecuteBtn) begin
      exec_cnt <= 8;
      pf <= F;
      pr <= R;
    end else if (exec_cnt != 0) begin
      exec_cnt <= exec_cnt - 1;
      if (exec_cnt == 1) begin
        case (pr)
          2'b00: pa <= alu(pf, pa, pb);
          2'b01: pb <= alu(pf, pa, pb);
          2'b10: begin pa <= pb; pb <= pa; end
          default: ;
        endcase
      end
    end
  end

  assign Aval = pa;
  assign Bval = pb;

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q[$];   // {ResA, ResB, ErrCount} expected after each command
  logic [7:0]  exp_err = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // {LoadA, LoadB, exec pressed, reset pressed, Done, Busy, CmdReady, Mismatch, Din, F, R}
  function automatic logic [22:0] obs();
    return {LoadA, LoadB, ~ExecuteBtn, ~ResetBtn, Done, Busy, CmdReady, Mismatch, Din, F, R};
  endfunction

  function automatic cmd_t mk(op_e op, logic [7:0] d, logic [2:0] f, logic [1:0] r,
                              logic [7:0] ea, logic [7:0] eb);
    cmd_t c;
    c.op = op; c.data = d; c.f = f; c.r = r; c.exp_a = ea; c.exp_b = eb;
    return c;
  endfunction

  // ---------------- driver ----------------
  // Issues one command and checks every cycle from accept+1 onward.
  // hold: keep CmdValid high until Done. rst_at: assert Reset after the
  // sample at that cycle offset (0 = never).
  task automatic run_cmd(input cmd_t c, input bit hold, input bit exp_mis,
                         input logic [7:0] want_a, input logic [7:0] want_b,
                         input logic [7:0] want_err, input int rst_at);
    int lat, lim, waited;
    bit aborted, act_press, done_e, busy_e;
    logic [3:0]  btn;
    logic [22:0] req;
    logic [23:0] w;
    lat = (c.op == OP_EXEC) ? 25 : 12;
    lim = (rst_at > 0) ? rst_at + 15 : lat + 2;
    exp_q.push_back({want_a, want_b, want_err});
    @(negedge Clk);
    CmdValid = 1'b1;
    Cmd = c;
    waited = 0;
    while (!CmdReady && waited < 50) begin
      @(negedge Clk);
      waited++;
    end
    if (!CmdReady) begin
      check("ready_timeout", 32'(CmdReady), 32'd1);
      CmdValid = 1'b0;
      return;
    end
    for (int k = 1; k <= lim; k++) begin
      @(negedge Clk);
      aborted = (rst_at > 0) && (k > rst_at);
      if (aborted) begin
        req = {4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'b000, 2'b00};
      end else begin
        act_press = (k >= 4) && (k <= 7);
        btn    = act_press ? button_of(c.op) : 4'b0000;
        done_e = (k == lat);
        busy_e = (k <= lat);
        req = {btn, done_e, busy_e, ~busy_e, done_e & exp_mis, c.data, c.f, c.r};
      end
      check($sformatf("cyc op=%0d k=%0d", c.op, k), 32'(obs()), 32'(req));
      if (rst_at > 0 && k == rst_at + 1) begin
        check("state_after_reset", 32'(dbg_state), 32'(IDLE));
        Reset = 1'b0;
      end
      if (rst_at > 0 && k == rst_at) begin
        CmdValid = 1'b0;
        Reset = 1'b1;
      end
      if (!hold && k == 1) CmdValid = 1'b0;
      if (hold && k == lat) CmdValid = 1'b0;
    end
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check($sformatf("result op=%0d", c.op), 32'({ResA, ResB, ErrCount}), 32'(w));
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    op_e        op;
    logic [7:0] data;
    logic [2:0] f;
    logic [1:0] r;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] want_a;
    logic [7:0] want_b;
    logic [7:0] want_pa;
  } vec_t;

  vec_t vecs[11];
  cmd_t c5;

  initial begin
    vecs[0]  = '{OP_LDA,  8'h33, 3'b000, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33};
    vecs[1]  = '{OP_LDB,  8'h55, 3'b000, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33};
    vecs[2]  = '{OP_EXEC, 8'h00, 3'b000, 2'b00, 8'h11, 8'h55, 8'h11, 8'h55, 8'h11};
    vecs[3]  = '{OP_LDB,  8'h0F, 3'b000, 2'b00, 8'h00, 8'h00, 8'h11, 8'h55, 8'h11};
    vecs[4]  = '{OP_EXEC, 8'h0F, 3'b001, 2'b01, 8'h11, 8'h1F, 8'h11, 8'h1F, 8'h11};
    vecs[5]  = '{OP_EXEC, 8'h0F, 3'b010, 2'b10, 8'h1F, 8'h11, 8'h1F, 8'h11, 8'h1F};
    vecs[6]  = '{OP_RST,  8'h0F, 3'b010, 2'b10, 8'h00, 8'h00, 8'h1F, 8'h11, 8'h00};
    vecs[7]  = '{OP_LDA,  8'hA5, 3'b000, 2'b00, 8'h00, 8'h00, 8'h1F, 8'h11, 8'hA5};
    vecs[8]  = '{OP_LDB,  8'h3C, 3'b000, 2'b00, 8'h00, 8'h00, 8'h1F, 8'h11, 8'hA5};
    vecs[9]  = '{OP_EXEC, 8'h3C, 3'b010, 2'b00, 8'h99, 8'h3C, 8'h99, 8'h3C, 8'h99};
    vecs[10] = '{OP_EXEC, 8'h3C, 3'b011, 2'b11, 8'h99, 8'h3C, 8'h99, 8'h3C, 8'h99};

    // reset
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("reset_outputs", 32'(obs()), 32'({4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'b000, 2'b00}));
    check("reset_results", 32'({ResA, ResB, ErrCount}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));

    // table: loads, executes across functions and routings, processor reset
    for (int i = 0; i < 11; i++) begin
      run_cmd(mk(vecs[i].op, vecs[i].data, vecs[i].f, vecs[i].r, vecs[i].ea, vecs[i].eb),
              1'b0, 1'b0, vecs[i].want_a, vecs[i].want_b, exp_err, 0);
      check($sformatf("proc_a vec%0d", i), 32'(pa), 32'(vecs[i].want_pa));
    end

    // CmdValid held high through an EXEC: 99 & 3C = 18
    run_cmd(mk(OP_EXEC, 8'h3C, 3'b000, 2'b00, 8'h18, 8'h3C), 1'b1, 1'b0, 8'h18, 8'h3C, exp_err, 0);
    @(negedge Clk);
    check("no_second_accept", 32'({Busy, Done}), 32'd0);

    // Reset during PRESS of LDB: abandoned, everything back to reset values
    exp_err = 8'h00;
    run_cmd(mk(OP_LDB, 8'h5A, 3'b000, 2'b00, 8'h00, 8'h00), 1'b0, 1'b0, 8'h00, 8'h00, exp_err, 5);
    run_cmd(mk(OP_LDA, 8'h77, 3'b000, 2'b00, 8'h00, 8'h00), 1'b0, 1'b0, 8'h00, 8'h00, exp_err, 0);
    check("proc_a_after_abort", 32'(pa), 32'h77);

    // Miscompare: 77 & 5A = 52, then 52 & 5A = 52; expected A is FF
    c5 = mk(OP_EXEC, 8'h77, 3'b000, 2'b00, 8'hFF, 8'h5A);
`ifdef PROC_DRV_CHECK_EN
    for (int i = 0; i < 300; i++) begin
      exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
      run_cmd(c5, 1'b0, 1'b1, 8'h52, 8'h5A, exp_err, 0);
    end
    check("err_saturated", 32'(ErrCount), 32'hFF);
`else
    for (int i = 0; i < 3; i++) begin
      run_cmd(c5, 1'b0, 1'b0, 8'h52, 8'h5A, 8'h00, 0);
    end
    check("err_off", 32'(ErrCount), 32'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
